// File: rtl/load_data_if.sv
// Load request / memory read bundle between the control FSM, the load data unit and data memory.
// The master side is the environment: control unit requests plus the memory read port.
interface load_data_if;
  logic        start;
  logic [2:0]  load_type;
  logic [31:0] addr_in;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        done;
  logic [31:0] load_data;
  logic        misaligned;

  modport master (
    output start, load_type, addr_in, mem_rdata,
    input  mem_addr, busy, done, load_data, misaligned
  );

  modport slave (
    input  start, load_type, addr_in, mem_rdata,
    output mem_addr, busy, done, load_data, misaligned
  );
endinterface

// File: rtl/load_data_unit.sv
// Load data unit: issues a word-aligned read and returns the LW/LH/LHU/LB/LBU extended result.
// Defining LOAD_ALIGN_CHECK_EN enables misaligned LW/LH/LHU fault reporting.
module load_data_unit #(
  parameter int unsigned MEM_LAT = 2
) (
  input logic        clk,
  input logic        reset,
  load_data_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic [1:0]  lane_q, lane_d;
  logic [2:0]  type_q, type_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] load_data_q, load_data_d;
  logic        misaligned_q, misaligned_d;
  logic        fault;
  logic [15:0] half;
  logic [7:0]  lane_byte;
  logic [31:0] extended;

  // Lane extraction works on the latched address bits, not the live request.
  always_comb begin
    half      = lane_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    lane_byte = bus.mem_rdata[7:0];
    unique case (lane_q)
      2'd0: lane_byte = bus.mem_rdata[7:0];
      2'd1: lane_byte = bus.mem_rdata[15:8];
      2'd2: lane_byte = bus.mem_rdata[23:16];
      2'd3: lane_byte = bus.mem_rdata[31:24];
    endcase
    case (type_q)
      3'b001:  extended = {{16{half[15]}}, half};
      3'b010:  extended = {16'h0000, half};
      3'b011:  extended = {{24{lane_byte[7]}}, lane_byte};
      3'b100:  extended = {24'h000000, lane_byte};
      default: extended = bus.mem_rdata;
    endcase
  end

`ifdef LOAD_ALIGN_CHECK_EN
  always_comb begin
    case (bus.load_type)
      3'b001, 3'b010: fault = bus.addr_in[0];
      3'b011, 3'b100: fault = 1'b0;
      default:        fault = (bus.addr_in[1:0] != 2'b00);
    endcase
  end
`else
  assign fault = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    lane_d       = lane_q;
    type_d       = type_q;
    mem_addr_d   = mem_addr_q;
    load_data_d  = load_data_q;
    misaligned_d = misaligned_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          lane_d       = bus.addr_in[1:0];
          type_d       = bus.load_type;
          misaligned_d = fault;
          // A faulting request never touches memory or the result register.
          if (fault) begin
            state_d = StDone;
          end else begin
            mem_addr_d = {bus.addr_in[31:2], 2'b00};
            count_d    = 4'(MEM_LAT);
            state_d    = StWait;
          end
        end
      end
      StWait: begin
        if (count_q == 4'd1) begin
          load_data_d = extended;
          count_d     = 4'd0;
          state_d     = StDone;
        end else begin
          count_d = count_q - 4'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      count_q      <= 4'd0;
      lane_q       <= 2'd0;
      type_q       <= 3'd0;
      mem_addr_q   <= 32'd0;
      load_data_q  <= 32'd0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      lane_q       <= lane_d;
      type_q       <= type_d;
      mem_addr_q   <= mem_addr_d;
      load_data_q  <= load_data_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign bus.mem_addr   = mem_addr_q;
  assign bus.busy       = (state_q == StWait);
  assign bus.done       = (state_q == StDone);
  assign bus.load_data  = load_data_q;
  assign bus.misaligned = misaligned_q;

endmodule

// File: tb/tb_load_data_unit.sv
// Scoreboard bench for load_data_unit: directed loads from the test plan, then random loads
// checked against a byte/halfword arithmetic reference model.
module tb_load_data_unit;
  localparam int unsigned MEM_LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int unsigned cyc = 0;
  int          checks = 0;
  int          passes = 0;

  load_data_if bus ();

  load_data_unit #(.MEM_LAT(MEM_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] data;
    int unsigned cyc;
    logic        mis;
  } exp_t;

  typedef struct {
    logic [2:0]  t;
    logic [31:0] a;
    logic [31:0] d;
    bit          poke;
  } vec_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  vec_t        dir[12];
  logic [31:0] last_data = 32'd0;
  logic [31:0] last_addr = 32'd0;
  logic [31:0] shown_data = 32'd0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h100) return 32'h81807F01;
    return (a * 32'h9E3779B1) ^ 32'hA5C30F96;
  endfunction

  assign bus.mem_rdata = mem_word(bus.mem_addr);

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] t,
                                           input logic [31:0] a);
    int unsigned b;
    int unsigned h;
    int unsigned bsel;
    int unsigned hsel;
    bsel = a % 4;
    hsel = (a / 2) % 2;
    b = (w / (32'd1 << (8 * bsel))) % 256;
    h = (w / (32'd1 << (16 * hsel))) % 65536;
    case (t)
      3'd1:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
      3'd2:    return h;
      3'd3:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
      3'd4:    return b;
      default: return w;
    endcase
  endfunction

  function automatic bit ref_mis(input logic [2:0] t, input logic [31:0] a);
`ifdef LOAD_ALIGN_CHECK_EN
    if (t == 3'd3 || t == 3'd4) return 1'b0;
    if (t == 3'd1 || t == 3'd2) return (a % 2) != 0;
    return (a % 4) != 0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
  endtask

  // Monitor: every done pulse is matched against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL spurious_done: done=1, required 0 (cycle %0d)", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("load_data", bus.load_data, mon_e.data);
          check("done_cycle", cyc, mon_e.cyc);
          check("misaligned", 32'(bus.misaligned), 32'(mon_e.mis));
          check("busy_in_done", 32'(bus.busy), 32'd0);
          shown_data = mon_e.data;
        end
      end else begin
        check("load_data_hold", bus.load_data, shown_data);
      end
    end
  end

  task automatic issue(input logic [2:0] t, input logic [31:0] a, input bit poke,
                       input bit use_given, input logic [31:0] given);
    exp_t        e;
    bit          mis;
    logic [31:0] aligned;
    int          n;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.load_type = t;
    bus.addr_in   = a;
    mis     = ref_mis(t, a);
    aligned = (a / 4) * 4;
    e.mis   = mis;
    e.cyc   = cyc + 1 + (mis ? 0 : MEM_LAT);
    if (mis) e.data = last_data;
    else e.data = use_given ? given : ref_load(mem_word(aligned), t, a);
    if (!mis) begin
      last_data = e.data;
      last_addr = aligned;
    end
    exp_q.push_back(e);
    @(negedge clk);
    check("busy_after_accept", 32'(bus.busy), 32'(!mis));
    check("mem_addr", bus.mem_addr, last_addr);
    // Request lines change after acceptance; a poke also re-asserts start mid-flight.
    bus.start     = poke;
    bus.addr_in   = poke ? 32'h200 : $urandom;
    bus.load_type = 3'($urandom_range(0, 7));
    n = 0;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      bus.start = 1'b0;
      n++;
    end
    if (!bus.done) begin
      checks++;
      $display("FAIL done_timeout: done=0 after %0d cycles, required 1", n);
      exp_q.delete();
    end else begin
      // Start during the done cycle must be ignored.
      bus.start   = 1'($urandom_range(0, 1));
      bus.addr_in = $urandom;
      @(negedge clk);
      bus.start = 1'b0;
    end
  endtask

  task automatic reset_mid_wait();
    @(negedge clk);
    bus.start     = 1'b1;
    bus.load_type = 3'd0;
    bus.addr_in   = 32'h100;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.addr_in = 32'h200;
    check("busy_before_reset", 32'(bus.busy), 32'd1);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_load_data", bus.load_data, 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_misaligned", 32'(bus.misaligned), 32'd0);
    exp_q.delete();
    last_data  = 32'd0;
    last_addr  = 32'd0;
    shown_data = 32'd0;
    @(negedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  initial begin
    bus.start     = 1'b0;
    bus.load_type = 3'd0;
    bus.addr_in   = 32'd0;
    dir[0]  = '{3'd0, 32'h100, 32'h81807F01, 1'b1};
    dir[1]  = '{3'd3, 32'h103, 32'hFFFFFF81, 1'b0};
    dir[2]  = '{3'd4, 32'h103, 32'h00000081, 1'b0};
    dir[3]  = '{3'd3, 32'h101, 32'h0000007F, 1'b0};
    dir[4]  = '{3'd4, 32'h100, 32'h00000001, 1'b0};
    dir[5]  = '{3'd1, 32'h100, 32'h00007F01, 1'b0};
    dir[6]  = '{3'd1, 32'h102, 32'hFFFF8180, 1'b0};
    dir[7]  = '{3'd2, 32'h102, 32'h00008180, 1'b1};
    dir[8]  = '{3'd7, 32'h100, 32'h81807F01, 1'b0};
    dir[9]  = '{3'd3, 32'h101, 32'h0000007F, 1'b0};
`ifdef LOAD_ALIGN_CHECK_EN
    dir[10] = '{3'd0, 32'h101, 32'h0000007F, 1'b0};
`else
    dir[10] = '{3'd0, 32'h101, 32'h81807F01, 1'b0};
`endif
    dir[11] = '{3'd3, 32'h101, 32'h0000007F, 1'b0};

    #1;
    check("init_busy", 32'(bus.busy), 32'd0);
    check("init_done", 32'(bus.done), 32'd0);
    check("init_load_data", bus.load_data, 32'd0);
    check("init_mem_addr", bus.mem_addr, 32'd0);
    check("init_misaligned", 32'(bus.misaligned), 32'd0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 12; i++) issue(dir[i].t, dir[i].a, dir[i].poke, 1'b1, dir[i].d);
    reset_mid_wait();
    issue(3'd0, 32'h100, 1'b0, 1'b1, 32'h81807F01);

    for (int i = 0; i < 300; i++) begin
      issue(3'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 3) == 0), 1'b0, 32'd0);
    end

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL pending_loads: %0d outstanding, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/load_data_unit.md
Name: load_data_unit

Overview:
- Read-side counterpart of the memory write-data path: issues a word read to data memory and returns the loaded value to the register-file write path.
- Performs LW/LH/LHU/LB/LBU lane extraction and sign/zero extension.
- Sits between the multicycle control unit and data memory.
- Uses a start/busy/done handshake so the control FSM can stall for the memory's read latency.

Parameters:
- MEM_LAT, 2, clock cycles from mem_addr valid to mem_rdata valid; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  load request; sampled only in IDLE
- load_type  input  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU; 101-111 treated as LW
- addr_in  input  32  byte address of load
- mem_addr  output  32  word-aligned address to data memory
- mem_rdata  input  32  word returned by memory
- busy  output  1  high while request in flight
- done  output  1  one-cycle pulse, load_data valid
- load_data  output  32  extended load result
- misaligned  output  1  alignment fault flag; see Optional Feature

Behaviour:
- Reset, asynchronous, all outputs zero:
  - state=IDLE, mem_addr=0, busy=0, done=0, load_data=0, misaligned=0, internal latch/counter=0.
- FSM states IDLE, WAIT, DONE:
  - IDLE: on start=1 at edge T, latch addr_in and load_type, set mem_addr={addr_in[31:2],2'b00}, counter=MEM_LAT, busy=1, go to WAIT.
  - WAIT: counter decrements each edge. When counter reaches 1, at that edge capture mem_rdata into the extractor and register load_data, then go to DONE.
  - DONE: done=1 and busy=0 for exactly one cycle, then return to IDLE.
- Latency:
  - done is high in cycle T+MEM_LAT+1; with MEM_LAT=2, done is at T+3.
  - Back-to-back: a start asserted during the DONE cycle is ignored. Next accepted start is the first IDLE cycle.
- start while busy or in DONE: ignored, no queueing.
- mem_addr holds its last value after completion; it changes only on an accepted start.
- Extraction is little-endian, on the latched address:
  - LW: whole word.
  - LH/LHU: addr[1]=0 selects [15:0], addr[1]=1 selects [31:16]; sign- or zero-extend to 32.
  - LB/LBU: addr[1:0] selects byte lane n = bits [8n+7:8n]; sign- or zero-extend.
- load_data holds until the next completed load; it never changes outside a capture edge.
- Reset asserted mid-WAIT: immediate return to IDLE, no done pulse, load_data cleared.
- addr_in/load_type changes after acceptance have no effect.

Optional Feature:
- Macro LOAD_ALIGN_CHECK_EN.
- Defined:
  - On accepted start, LW with addr_in[1:0]!=0, or LH/LHU with addr_in[0]=1, counts as misaligned.
  - A misaligned request skips WAIT and goes IDLE->DONE. done pulses at T+1 with misaligned=1; mem_addr and load_data are unchanged.
  - misaligned clears on the next accepted start or on reset.
  - Byte loads never fault.
- Undefined: misaligned is tied 0. Low address bits beyond the lane selection above are ignored; LW uses the aligned word.

Test Plan:
- Memory word 0x81807F01 at 0x100, MEM_LAT=2. LW addr 0x100 at T -> mem_addr=0x100 at T+1, done at T+3, load_data=0x81807F01, busy high T+1..T+2.
- LB 0x103 -> 0xFFFFFF81. LBU 0x103 -> 0x00000081. LB 0x101 -> 0x0000007F. LBU 0x100 -> 0x00000001.
- LH 0x100 -> 0x00007F01. LH 0x102 -> 0xFFFF8180. LHU 0x102 -> 0x00008180. load_type=111 at 0x100 -> 0x81807F01.
- Handshake and reset:
  - LW accepted, start re-pulsed at T+1 with addr 0x200 -> ignored, result from 0x100.
  - Reset at T+2 -> no done, load_data=0, busy=0 immediately.
  - Fresh start after reset completes normally.
- With LOAD_ALIGN_CHECK_EN: LW 0x101 -> done at T+1, misaligned=1, load_data unchanged, mem_addr unchanged; following LB 0x101 -> misaligned=0, load_data=0x0000007F. Without the macro: LW 0x101 -> 0x81807F01 at T+3, misaligned=0.
